// File: rtl/regfile_wb_arbiter.sv
// Write-side front end for the register file: merges ALU and load
// writebacks into the single write port and tracks outstanding writes.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [ADDR_W-1:0]             ld_rd,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_rd,
    output logic                          rf_we3,
    output logic [ADDR_W-1:0]             rf_a3,
    output logic [DATA_W-1:0]             rf_wd3,
    output logic [2**ADDR_W-1:0]          busy_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG    = 2**ADDR_W;

    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STALL_W-1:0] STARVE_V = STALL_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [STALL_W-1:0] STL_ONE  = STALL_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [STALL_W-1:0] stall_cnt;

    logic              fifo_empty;
    logic              starve;
    logic              alu_grant;
    logic              fifo_grant;
    logic              push;
    logic              pop;
    wb_t               win;
    logic [NREG-1:0]   busy_nxt;

    // Arbitration: the ALU normally yields to buffered loads, but wins
    // once it has been stalled STARVE_LIMIT cycles in a row.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        starve     = (stall_cnt == STARVE_V);
        alu_grant  = alu_valid && (fifo_empty || starve);
        fifo_grant = !alu_grant && !fifo_empty;
        alu_ready  = alu_grant;
        ld_ready   = (fifo_count != FULL_CNT);
        push       = ld_valid && ld_ready;
        pop        = fifo_grant;
    end

    always_comb begin
        win = '0;
        unique case (1'b1)
            alu_grant:  win = '{rd: alu_rd, data: alu_data};
            fifo_grant: win = fifo_mem[rd_ptr];
            default:    win = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (alu_valid && !alu_ready) begin
            if (!starve) begin
                stall_cnt <= stall_cnt + STL_ONE;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // x0 grants complete the handshake but never reach the write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we3 <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else if ((alu_grant || fifo_grant) && (win.rd != '0)) begin
            rf_we3 <= 1'b1;
            rf_a3  <= win.rd;
            rf_wd3 <= win.data;
        end else begin
            rf_we3 <= 1'b0;
        end
    end

    // A new issue to the register being committed keeps it busy.
    always_comb begin
        busy_nxt = busy_mask;
        if (rf_we3) begin
            busy_nxt[rf_a3] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: table of single ALU writes plus
// hand-built sequences for FIFO priority, starvation, full, x0 and reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        ld_valid    = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{rd: 5'd1,  data: 32'h1111_0001, exp_we: 1'b1, exp_busy: 32'h0000_0002};
        vecs[1] = '{rd: 5'd31, data: 32'hA5A5_A5A5, exp_we: 1'b1, exp_busy: 32'h8000_0000};
        vecs[2] = '{rd: 5'd0,  data: 32'h1234_5678, exp_we: 1'b0, exp_busy: 32'h0000_0000};
        vecs[3] = '{rd: 5'd16, data: 32'h0000_0000, exp_we: 1'b1, exp_busy: 32'h0001_0000};

        // Reset with both sources requesting
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_valid = 1'b1;  ld_rd = 5'd3;  ld_data = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick();
        tick();
        chk("rst_we3", rf_we3, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ld_ready", ld_ready, 1);

        // Release, issue rd5, then ALU write to rd5
        rst_n = 1'b1;
        idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        chk("post_rst_we3", rf_we3, 0);
        chk("issue5_busy", busy_mask, 32'h20);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("alu_ready", alu_ready, 1);
        tick();
        chk("alu_we3", rf_we3, 1);
        chk("alu_a3", rf_a3, 5);
        chk("alu_wd3", rf_wd3, 32'hDEAD_BEEF);
        chk("alu_busy_pre", busy_mask, 32'h20);
        alu_valid = 1'b0;
        tick();
        chk("alu_we3_off", rf_we3, 0);
        chk("alu_busy_clr", busy_mask, 0);
        chk("hold_a3", rf_a3, 5);
        chk("hold_wd3", rf_wd3, 32'hDEAD_BEEF);

        // Table: issue and ALU write of the same rd in one cycle
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_rd = vecs[i].rd;
            alu_valid = 1'b1; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
            #1;
            chk("vec_alu_ready", alu_ready, 1);
            tick();
            chk("vec_we3", rf_we3, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                chk("vec_a3", rf_a3, vecs[i].rd);
                chk("vec_wd3", rf_wd3, vecs[i].data);
            end
            chk("vec_busy", busy_mask, vecs[i].exp_busy);
            idle();
            tick();
            chk("vec_we3_off", rf_we3, 0);
            chk("vec_busy_clr", busy_mask, 0);
        end

        // FIFO priority and starvation: rd1, rd2, rd3, ALU, rd4
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h10;
        tick();
        chk("prio_cnt1", fifo_count, 1);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_rd = 5'd2; ld_data = 32'h20;
        #1;
        chk("prio_alu_wait1", alu_ready, 0);
        tick();
        chk("prio_w1", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd1, 32'h10});
        ld_rd = 5'd3; ld_data = 32'h30;
        tick();
        chk("prio_w2", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd2, 32'h20});
        ld_rd = 5'd4; ld_data = 32'h40;
        #1;
        chk("prio_alu_wait3", alu_ready, 0);
        tick();
        chk("prio_w3", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd3, 32'h30});
        ld_valid = 1'b0;
        #1;
        chk("prio_starve", alu_ready, 1);
        tick();
        chk("prio_w_alu", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd9, 32'h99});
        chk("prio_cnt_alu", fifo_count, 1);
        alu_valid = 1'b0;
        tick();
        chk("prio_w4", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd4, 32'h40});
        chk("prio_cnt0", fifo_count, 0);
        tick();
        chk("prio_idle", rf_we3, 0);

        // Fill to full: only starvation grants let the FIFO grow
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        ld_valid = 1'b1;  ld_rd = 5'd8;   ld_data = 32'h88;
        n = 0;
        while (fifo_count != 3'd4 && n < 40) begin
            tick();
            n++;
        end
        chk("fill_cycles", n, 13);
        chk("full_ld_ready", ld_ready, 0);
        chk("full_alu_ready", alu_ready, 0);
        tick();
        chk("full_pop_cnt", fifo_count, 3);
        chk("full_pop_ready", ld_ready, 1);
        tick();
        chk("pushpop_cnt", fifo_count, 3);
        idle();
        tick();
        tick();
        tick();
        chk("drain_cnt", fifo_count, 0);
        tick();

        // x0 load and x0 issue
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("x0_ld_ready", ld_ready, 1);
        tick();
        chk("x0_cnt1", fifo_count, 1);
        chk("x0_busy", busy_mask, 0);
        idle();
        tick();
        chk("x0_popped", fifo_count, 0);
        chk("x0_we3_a", rf_we3, 0);
        tick();
        chk("x0_we3_b", rf_we3, 0);

        // Scoreboard race on rd7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        chk("race_busy_set", busy_mask, 32'h80);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        chk("race_we3", {rf_we3, rf_a3}, {1'b1, 5'd7});
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        chk("race_set_wins", busy_mask, 32'h80);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_data = 32'h78;
        tick();
        chk("race_w2", {rf_we3, rf_wd3}, {1'b1, 32'h78});
        alu_valid = 1'b0;
        tick();
        chk("race_busy_clr", busy_mask, 0);

        // Reset mid-operation drops the queued load and its grant
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        chk("mid_cnt1", fifo_count, 1);
        chk("mid_busy", busy_mask, 32'h1000);
        idle();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cnt", fifo_count, 0);
        chk("mid_rst_we3", rf_we3, 0);
        chk("mid_rst_busy", busy_mask, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_after_we3", rf_we3, 0);
        tick();
        chk("mid_after2_we3", rf_we3, 0);
        chk("mid_after_cnt", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
